// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill path.
// Holds address-field positions, line geometry, the refill FSM states and the tree-PLRU touch helper.
package icache_pkg;
  localparam int TAG_W          = 25;
  localparam int WAYS           = 8;
  localparam int WORDS_PER_LINE = 16;
  localparam int LINE_W         = 512;
  localparam int OFFSET_W       = 6;
  localparam int INDEX_LSB      = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    FILL   = 3'd2,
    WRITE  = 3'd3,
    SETTLE = 3'd4
  } state_t;

  // Tree bits point at the colder half: after a touch every bit on the path points away from the way.
  function automatic logic [6:0] plruTouch(input logic [6:0] tree, input logic [2:0] way);
    logic [6:0] t;
    logic [2:0] leaf;
    t    = tree;
    t[0] = ~way[2];
    if (way[2]) t[2] = ~way[1];
    else        t[1] = ~way[1];
    leaf    = 3'd3 + {1'b0, way[2:1]};
    t[leaf] = ~way[0];
    return t;
  endfunction
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Line-fill memory bus between the refill controller (master) and the memory side (slave).
// memReq/memGnt: the request and memAddr hold until the cycle memGnt is seen with memReq; memValid qualifies memData each beat.
interface icache_refill_ctrl_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memValid;
  logic [31:0] memData;

  modport master (output memReq, memAddr, input  memGnt, memValid, memData);
  modport slave  (input  memReq, memAddr, output memGnt, memValid, memData);
endinterface

// File: rtl/icache_victim_sel.sv
// Per-set victim selection: lowest unfilled way first, then a replacement policy.
// ICACHE_PLRU_EN selects 7-bit tree PLRU (hits and fills update it); otherwise a 3-bit round-robin pointer.
module icache_victim_sel #(
  parameter int NUM_SETS = 2,
  parameter int SET_W    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SET_W-1:0] setIdx,
  input  logic             hitEn,
  input  logic [2:0]       hitWay,
  input  logic             writeEn,
  output logic [7:0]       victim
);
  import icache_pkg::*;

  logic [7:0] filled [NUM_SETS];
  logic [7:0] freeMask;
  logic [2:0] freeWay;
  logic [2:0] policyWay;
  logic [2:0] victimWay;
  logic       allFilled;

  always_comb begin
    freeMask = ~filled[setIdx];
    freeWay  = '0;
    for (int i = 7; i >= 0; i--) begin
      if (freeMask[i]) freeWay = 3'(i);
    end
    allFilled = (freeMask == '0);
    victimWay = allFilled ? policyWay : freeWay;
    victim    = 8'b1 << victimWay;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) filled[s] <= '0;
    end else if (writeEn) begin
      filled[setIdx] <= filled[setIdx] | victim;
    end
  end

`ifdef ICACHE_PLRU_EN
  logic [6:0] tree [NUM_SETS];
  logic [6:0] cur;
  logic [2:0] leafIdx;

  always_comb begin
    cur          = tree[setIdx];
    policyWay    = '0;
    policyWay[2] = cur[0];
    policyWay[1] = cur[0] ? cur[2] : cur[1];
    leafIdx      = 3'd3 + {1'b0, policyWay[2:1]};
    policyWay[0] = cur[leafIdx];
  end

  // Hits only occur in IDLE and fills only in WRITE, so the two updates never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
    end else if (writeEn) begin
      tree[setIdx] <= plruTouch(cur, victimWay);
    end else if (hitEn) begin
      tree[setIdx] <= plruTouch(cur, hitWay);
    end
  end
`else
  logic [2:0] rrPtr [NUM_SETS];
  logic       unusedHit;

  assign unusedHit = hitEn ^ (^hitWay);

  always_comb policyWay = rrPtr[setIdx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) rrPtr[s] <= '0;
    end else if (writeEn && allFilled) begin
      rrPtr[setIdx] <= rrPtr[setIdx] + 3'd1;
    end
  end
`endif
endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss detection and 16-beat line refill for the 8-way instruction cache.
// Outputs are decodes of the registered state; dbgState exposes the FSM.
module icache_refill_ctrl #(
  parameter int NUM_SETS = 2,
  parameter int WAYS     = 8,
  parameter int TAG_W    = 25
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpuReq,
  input  logic [31:0]                cpuAddr,
  output logic                       cpuReady,
  input  logic                       cacheHit,
  input  logic [2:0]                 hitWay,
  output logic [NUM_SETS-1:0]        setSel,
  output logic [TAG_W-1:0]           cpuTag,
  output logic [5:0]                 cpuOffset,
  output logic [icache_pkg::LINE_W-1:0] line0,
  output logic [TAG_W-1:0]           tag0,
  output logic                       v0,
  output logic [WAYS-1:0]            lineSelect,
  output logic                       memWrite,
  icache_refill_ctrl_if.master       memBus,
  output logic [2:0]                 dbgState
);
  import icache_pkg::*;

  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;

  state_t             state, nextState;
  logic [TAG_W-1:0]   tagQ;
  logic [SET_W-1:0]   idxQ, setIdx;
  logic [3:0]         beatCnt;
  logic [LINE_W-1:0]  lineBuf;
  logic [7:0]         victim;
  logic [31:0]        reqAddr;
  logic               missDetect, hitEn;

  assign setIdx     = (state == IDLE) ? cpuAddr[INDEX_LSB +: SET_W] : idxQ;
  assign missDetect = (state == IDLE) && cpuReq && !cacheHit;
  assign hitEn      = (state == IDLE) && cpuReq && cacheHit;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (missDetect) nextState = REQ;
      REQ:    if (memBus.memGnt) nextState = FILL;
      FILL:   if (memBus.memValid && beatCnt == 4'(WORDS_PER_LINE - 1)) nextState = WRITE;
      WRITE:  nextState = SETTLE;
      SETTLE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tagQ    <= '0;
      idxQ    <= '0;
      beatCnt <= '0;
      lineBuf <= '0;
    end else begin
      if (missDetect) begin
        tagQ <= cpuAddr[31 -: TAG_W];
        idxQ <= cpuAddr[INDEX_LSB +: SET_W];
      end
      if (state == REQ && memBus.memGnt) beatCnt <= '0;
      if (state == FILL && memBus.memValid) begin
        lineBuf[32*beatCnt +: 32] <= memBus.memData;
        beatCnt                   <= beatCnt + 4'd1;
      end
    end
  end

  icache_victim_sel #(.NUM_SETS(NUM_SETS), .SET_W(SET_W)) uVictim (
    .clk     (clk),
    .reset   (reset),
    .setIdx  (setIdx),
    .hitEn   (hitEn),
    .hitWay  (hitWay),
    .writeEn (state == WRITE),
    .victim  (victim)
  );

  always_comb begin
    setSel         = '0;
    setSel[setIdx] = 1'b1;
    reqAddr                     = '0;
    reqAddr[31 -: TAG_W]        = tagQ;
    reqAddr[INDEX_LSB +: SET_W] = idxQ;
  end

  assign cpuReady       = hitEn;
  assign cpuTag         = (state == IDLE) ? cpuAddr[31 -: TAG_W] : tagQ;
  assign cpuOffset      = cpuAddr[OFFSET_W-1:0];
  assign line0          = lineBuf;
  assign memWrite       = (state == WRITE);
  assign v0             = (state == WRITE);
  assign tag0           = (state == WRITE) ? tagQ : '0;
  assign lineSelect     = (state == WRITE) ? victim : '0;
  assign memBus.memReq  = (state == REQ);
  assign memBus.memAddr = (state == REQ) ? reqAddr : '0;
  assign dbgState       = state;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: misses, fills, victim order, stalls, drop and reset mid-refill.
module tb_icache_refill_ctrl;
  logic         clk, reset, cpuReq, cacheHit, cpuReady, v0, memWrite;
  logic [31:0]  cpuAddr;
  logic [2:0]   hitWay, dbgState;
  logic [1:0]   setSel;
  logic [24:0]  cpuTag, tag0;
  logic [5:0]   cpuOffset;
  logic [511:0] line0;
  logic [7:0]   lineSelect;
  int           assertCnt = 0;
  int           failCnt = 0;

  icache_refill_ctrl_if memBus ();

  icache_refill_ctrl #(.NUM_SETS(2), .WAYS(8), .TAG_W(25)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpuReq     (cpuReq),
    .cpuAddr    (cpuAddr),
    .cpuReady   (cpuReady),
    .cacheHit   (cacheHit),
    .hitWay     (hitWay),
    .setSel     (setSel),
    .cpuTag     (cpuTag),
    .cpuOffset  (cpuOffset),
    .line0      (line0),
    .tag0       (tag0),
    .v0         (v0),
    .lineSelect (lineSelect),
    .memWrite   (memWrite),
    .memBus     (memBus.master),
    .dbgState   (dbgState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no end expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    assertCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag, input logic [1:0] expSetSel);
    check({tag, "_cpuReady"},   cpuReady, 0);
    check({tag, "_cpuTag"},     cpuTag, 0);
    check({tag, "_cpuOffset"},  cpuOffset, 0);
    check({tag, "_line0"},      line0, 0);
    check({tag, "_tag0"},       tag0, 0);
    check({tag, "_v0"},         v0, 0);
    check({tag, "_lineSelect"}, lineSelect, 0);
    check({tag, "_memWrite"},   memWrite, 0);
    check({tag, "_memReq"},     memBus.memReq, 0);
    check({tag, "_memAddr"},    memBus.memAddr, 0);
    check({tag, "_setSel"},     setSel, expSetSel);
    check({tag, "_state"},      dbgState, 0);
  endtask

  // One refill. Cycle 0 is the request cycle; the memory grants after gntWait REQ cycles and
  // withholds stallN beats before beat stallAt. dropBeat >= 0 drops cpuReq once that many beats went out.
  task automatic runMiss(input string name, input logic [31:0] addr, input logic [31:0] base,
                         input int gntWait, input int stallAt, input int stallN, input int dropBeat,
                         input logic [7:0] expSel, input int expCycles);
    int cyc = 0, beat = 0, writes = 0, gntCnt = 0, stallLeft = stallN, writeCyc = -10;
    bit granted = 0, installed = 0, done = 0, gntNow, wrNow;
    logic [511:0] expLine;
    logic [24:0]  expTag;
    expTag = addr[31:7];
    for (int k = 0; k < 16; k++) expLine[32*k +: 32] = base + 32'(k);
    @(negedge clk);
    cpuReq = 1; cpuAddr = addr; cacheHit = 0; hitWay = 0;
    memBus.memGnt = 0; memBus.memValid = 0; memBus.memData = 0;
    while (!done && cyc <= 200) begin
      if (cyc > 0) begin
        @(negedge clk);
        cacheHit        = installed;
        memBus.memGnt   = 0;
        memBus.memValid = 0;
        if (memBus.memReq) begin
          memBus.memGnt = (gntCnt >= gntWait);
          gntCnt++;
        end
        if (granted && beat < 16) begin
          if (beat == stallAt && stallLeft > 0) stallLeft--;
          else begin
            memBus.memValid = 1;
            memBus.memData  = base + 32'(beat);
            beat++;
          end
        end
        if (dropBeat >= 0 && beat == dropBeat) cpuReq = 0;
      end
      #1;
      gntNow = memBus.memReq & memBus.memGnt;
      wrNow  = memWrite;
      if (memBus.memReq) begin
        check({name, "_memAddr"}, memBus.memAddr, {addr[31:6], 6'b0});
        check({name, "_cpuTagReq"}, cpuTag, expTag);
      end
      if (wrNow) begin
        writes++;
        writeCyc = cyc;
        check({name, "_lineSelect"}, lineSelect, expSel);
        check({name, "_tag0"}, tag0, expTag);
        check({name, "_v0"}, v0, 1);
        check({name, "_line0"}, line0, expLine);
      end
      if (cpuReady) begin
        done = 1;
        if (dropBeat < 0) check({name, "_cycles"}, cyc, expCycles);
        else check({name, "_readyAfterDrop"}, cpuReady, 0);
      end
      if (dropBeat >= 0 && installed && cyc == writeCyc + 2) begin
        done = 1;
        check({name, "_idleAfterDrop"}, dbgState, 0);
      end
      if (done) begin
        cpuReq = 0; cacheHit = 0;
      end else begin
        @(posedge clk);
        if (gntNow) granted = 1;
        if (wrNow) installed = 1;
        cyc++;
      end
    end
    check({name, "_finished"}, done, 1);
    check({name, "_writeCount"}, writes, 1);
  endtask

  task automatic hitCheck(input string name, input logic [31:0] addr, input logic [2:0] way,
                          input logic [1:0] expSetSel);
    @(negedge clk);
    cpuReq = 1; cpuAddr = addr; cacheHit = 1; hitWay = way;
    #1;
    check({name, "_cpuReady"}, cpuReady, 1);
    check({name, "_setSel"}, setSel, expSetSel);
    check({name, "_cpuTag"}, cpuTag, addr[31:7]);
    check({name, "_cpuOffset"}, cpuOffset, addr[5:0]);
    @(posedge clk);
    @(negedge clk);
    cpuReq = 0; cacheHit = 0; hitWay = 0;
  endtask

  initial begin
    reset = 1; cpuReq = 0; cpuAddr = 0; cacheHit = 0; hitWay = 0;
    memBus.memGnt = 0; memBus.memValid = 0; memBus.memData = 0;
    #1;
    checkAllZero("reset", 2'b01);
    repeat (2) @(negedge clk);
    reset = 0;

    runMiss("firstMiss", 32'h0000_0040, 32'h1000, 0, -1, 0, -1, 8'h01, 20);

    for (int k = 0; k < 8; k++)
      runMiss($sformatf("set0fill%0d", k), 32'(k) << 7, 32'h2000 + 32'(k * 16),
              0, -1, 0, -1, 8'h01 << k, 20);

    hitCheck("hitSet0Way0", 32'h0000_0000, 3'd0, 2'b01);
`ifdef ICACHE_PLRU_EN
    runMiss("evict9", 32'h0000_0400, 32'h5000, 0, -1, 0, -1, 8'h10, 20);
    runMiss("evict10", 32'h0000_0480, 32'h5100, 0, -1, 0, -1, 8'h04, 20);
`else
    runMiss("evict9", 32'h0000_0400, 32'h5000, 0, -1, 0, -1, 8'h01, 20);
    runMiss("evict10", 32'h0000_0480, 32'h5100, 0, -1, 0, -1, 8'h02, 20);
`endif

    runMiss("stalls", 32'h0000_00C0, 32'h6000, 5, 4, 3, -1, 8'h02, 28);
    runMiss("dropReq", 32'h0000_0140, 32'h7000, 0, -1, 0, 8, 8'h04, 20);

    hitCheck("hitSet1", 32'h0000_0044, 3'd1, 2'b10);

    // Reset arrives while beat 7 is on the bus.
    @(negedge clk);
    cpuReq = 1; cpuAddr = 32'h0000_01C0; cacheHit = 0;
    @(negedge clk);
    memBus.memGnt = 1;
    @(negedge clk);
    memBus.memGnt = 0;
    for (int k = 0; k < 7; k++) begin
      memBus.memValid = 1; memBus.memData = 32'h3000 + 32'(k);
      @(negedge clk);
    end
    #1;
    check("midFill_state", dbgState, 2);
    memBus.memValid = 1; memBus.memData = 32'h3007;
    reset = 1; cpuAddr = 32'h0000_0040; cpuReq = 0;
    #1;
    checkAllZero("rstAsync", 2'b10);
    @(posedge clk);
    #1;
    checkAllZero("rstNext", 2'b10);
    @(negedge clk);
    memBus.memValid = 0; memBus.memData = 0;
    reset = 0;

    runMiss("postReset", 32'h0000_01C0, 32'h4000, 0, -1, 0, -1, 8'h01, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule
